// File: rtl/alu_iterative_wrapper_pkg.sv
// Shared execute-stage definitions: ALU opcodes, operand sources, flag layout,
// multiplier states and the single-cycle ALU evaluation function.
package alu_iterative_wrapper_pkg;

  localparam int WORD = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_ADC = 4'd1,
    ALU_SUB = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_MUL = 4'd6
  } alu_control_signal;

  typedef enum logic [2:0] {
    FROM_REG         = 3'd0,
    FROM_IMM         = 3'd1,
    FROM_ACCUMULATOR = 3'd2,
    FROM_PC          = 3'd3,
    FROM_ZERO        = 3'd4,
    FROM_TWO         = 3'd5,
    FROM_PC_ALIGNED  = 3'd6
  } alu_input_source;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } status_register;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  typedef struct packed {
    logic [WORD-1:0] result;
    status_register  flags;
  } alu_result_t;

  // Logical ops leave C and V untouched; ALU_MUL is handled by the iterative unit.
  function automatic alu_result_t alu_compute(input alu_control_signal ctrl,
                                              input logic [WORD-1:0] a,
                                              input logic [WORD-1:0] b,
                                              input status_register flags_in);
    logic [WORD:0] sum;
    alu_result_t   r;
    case (ctrl)
      ALU_ADD: sum = {1'b0, a} + {1'b0, b};
      ALU_ADC: sum = {1'b0, a} + {1'b0, b} + {{WORD{1'b0}}, flags_in.c};
      ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + {{WORD{1'b0}}, 1'b1};
      ALU_AND: sum = {1'b0, a & b};
      ALU_OR:  sum = {1'b0, a | b};
      ALU_XOR: sum = {1'b0, a ^ b};
      default: sum = {(WORD+1){1'b0}};
    endcase
    r.result  = sum[WORD-1:0];
    r.flags   = flags_in;
    r.flags.n = r.result[WORD-1];
    r.flags.z = (r.result == {WORD{1'b0}});
    case (ctrl)
      ALU_ADD, ALU_ADC: begin
        r.flags.c = sum[WORD];
        r.flags.v = (a[WORD-1] == b[WORD-1]) && (r.result[WORD-1] != a[WORD-1]);
      end
      ALU_SUB: begin
        r.flags.c = sum[WORD];
        r.flags.v = (a[WORD-1] != b[WORD-1]) && (r.result[WORD-1] != a[WORD-1]);
      end
      default: begin
        r.flags.c = flags_in.c;
        r.flags.v = flags_in.v;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_iterative_wrapper_multiplier.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps,
// then a single DONE cycle presenting the low WIDTH bits of the product.
module alu_iter_multiplier
  import alu_iterative_wrapper_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  output mul_state_t       state_o,
  output logic [WIDTH-1:0] product_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  mul_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State and datapath registers
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      p_q     <= {WIDTH{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and next datapath values
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = MUL;
          a_d     = op_a_i;
          b_d     = op_b_i;
          p_d     = {WIDTH{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          p_d     = b_q[0] ? (p_q + a_q) : p_q;
          a_d     = a_q << 1;
          b_d     = b_q >> 1;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_q == LAST_STEP) ? DONE : MUL;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    state_o   = state_q;
    product_o = p_q;
  end

endmodule

// File: rtl/alu_iterative_wrapper.sv
// Execute-stage ALU front end: operand select, single-cycle ALU, flag register
// and a valid/ready handshake around the iterative multiplier.
module alu_iterative_wrapper
  import alu_iterative_wrapper_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ALIGN_BITS = 2
) (
  input  logic              clk_i,
  input  logic              reset_n_i,
  input  logic              is_valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  input  logic              update_flag_i,
  input  alu_control_signal alu_ctrl_sig_i,
  input  alu_input_source   alu_input_1_select_i,
  input  alu_input_source   alu_input_2_select_i,
  input  logic [WIDTH-1:0]  reg_data_1_i,
  input  logic [WIDTH-1:0]  reg_data_2_i,
  input  logic [WIDTH-1:0]  accumulator_i,
  input  logic [WIDTH-1:0]  immediate_i,
  input  logic [WIDTH-1:0]  program_counter_i,
  output logic              result_valid_o,
  output logic [WIDTH-1:0]  alu_result_o,
  output logic [3:0]        status_reg_o
);

  function automatic logic [WIDTH-1:0] select_operand(input alu_input_source sel,
                                                      input logic [WIDTH-1:0] reg_val,
                                                      input logic [WIDTH-1:0] imm,
                                                      input logic [WIDTH-1:0] acc,
                                                      input logic [WIDTH-1:0] pc,
                                                      input logic [WIDTH-1:0] pc_al);
    case (sel)
      FROM_REG:         return reg_val;
      FROM_IMM:         return imm;
      FROM_ACCUMULATOR: return acc;
      FROM_PC:          return pc;
      FROM_ZERO:        return {WIDTH{1'b0}};
      FROM_TWO:         return WIDTH'(2'd2);
      FROM_PC_ALIGNED:  return pc_al;
      default:          return {WIDTH{1'b0}};
    endcase
  endfunction

  status_register   status_q, status_d;
  logic             upd_q, upd_d;
  logic [WIDTH-1:0] pc_aligned_s, op1_s, op2_s, product_s;
  logic             accept_s, is_mul_s, start_s;
  mul_state_t       state_s;
  alu_result_t      alu_out_s;

  assign pc_aligned_s = program_counter_i & ({WIDTH{1'b1}} << ALIGN_BITS);
  assign op1_s = select_operand(alu_input_1_select_i, reg_data_1_i, immediate_i,
                                accumulator_i, program_counter_i, pc_aligned_s);
  assign op2_s = select_operand(alu_input_2_select_i, reg_data_2_i, immediate_i,
                                accumulator_i, program_counter_i, pc_aligned_s);

  assign ready_o      = (state_s == IDLE);
  assign accept_s     = is_valid_i & ready_o & ~flush_i;
  assign is_mul_s     = (alu_ctrl_sig_i == ALU_MUL);
  assign start_s      = accept_s & is_mul_s;
  assign alu_out_s    = alu_compute(alu_ctrl_sig_i, op1_s, op2_s, status_q);
  assign status_reg_o = status_q;

  alu_iter_multiplier #(.WIDTH(WIDTH)) u_mul (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .start_i   (start_s),
    .flush_i   (flush_i),
    .op_a_i    (op1_s),
    .op_b_i    (op2_s),
    .state_o   (state_s),
    .product_o (product_s)
  );

  // Flag register and latched update request for an in-flight MUL
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      status_q <= 4'b0000;
      upd_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      upd_q    <= upd_d;
    end
  end

  // Result presentation and next flags; MUL completion only touches N and Z
  always_comb begin
    result_valid_o = 1'b0;
    alu_result_o   = alu_out_s.result;
    status_d       = status_q;
    upd_d          = upd_q;
    case (state_s)
      IDLE: begin
        if (accept_s && !is_mul_s) begin
          result_valid_o = 1'b1;
          if (update_flag_i) begin
            status_d = alu_out_s.flags;
          end else begin
            status_d = status_q;
          end
        end else if (start_s) begin
          upd_d = update_flag_i;
        end else begin
          upd_d = upd_q;
        end
      end
      DONE: begin
        alu_result_o = product_s;
        if (!flush_i) begin
          result_valid_o = 1'b1;
          if (upd_q) begin
            status_d.n = product_s[WIDTH-1];
            status_d.z = (product_s == {WIDTH{1'b0}});
          end else begin
            status_d = status_q;
          end
        end else begin
          result_valid_o = 1'b0;
        end
      end
      default: result_valid_o = 1'b0;
    endcase
  end

endmodule
